instr_encoder_loader: RTL and testbench

Encodes RV32I instruction fields into 32-bit words for the classes our control decoder recognises: R-type, I-ALU, LOAD, STORE and BRANCH. Streams the encoded words into instruction memory at consecutive word addresses. Used as the program loader for the single-cycle core and for self-checking benches. It has a valid/ready input handshake, a one-entry output register with backpressure, and a session FSM that bounds the number of words written.

---
 rtl/instr_encoder_loader.sv | 110 +++++++++++
 tb/tb_instr_encoder_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I field bundles (R, I-ALU, LOAD, STORE, BRANCH) and streams them
// into instruction memory at consecutive word addresses within a bounded session.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [12:0] imm,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        accept, legal, complete;
    logic [31:0] enc;
    logic [16:0] committed;

    // A pending word already counts against the budget, so the next accept
    // can never push the session past MAX_WORDS.
    assign complete  = imem_we & imem_ready;
    assign committed = {1'b0, count} + {16'b0, imem_we};
    assign in_ready  = (state == RUN) && (!imem_we || imem_ready) &&
                       (committed < 17'(MAX_WORDS));
    assign accept    = in_valid & in_ready;
    assign legal     = (cls <= 3'd4);
    assign busy      = (state != IDLE);

    always_comb begin
        enc = '0;
        case (cls)
            3'd0: enc = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
            3'd1: begin
                // Shift-right immediates carry the SRAI/SRLI select in bit 30.
                if (funct3 == 3'b101)
                    enc = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011};
                else
                    enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            end
            3'd2: enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            3'd3: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            3'd4: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            default: enc = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (finish)   state_nxt = DRAIN;
            DRAIN:   if (!imem_we) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= (state == DRAIN) && !imem_we;
            if (state == IDLE && start) begin
                imem_addr <= BASE_ADDR;
                count     <= '0;
                err       <= 1'b0;
            end else begin
                if (complete) begin
                    count     <= count + 16'd1;
                    imem_addr <= imem_addr + 32'd4;
                end
                if (accept && !legal) err <= 1'b1;
            end
            if (accept && legal) begin
                imem_we    <= 1'b1;
                imem_wdata <= enc;
            end else if (complete) begin
                imem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued on
// accept and matched against every completed memory write.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, finish, in_valid, in_ready;
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [12:0] imm;
    logic        imem_we, imem_ready;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] count;
    logic        busy, done, err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    wr_t         mon_e;
    int          checks = 0, errors = 0, writes_seen = 0, done_seen = 0, cyc = 0;
    logic [31:0] exp_addr = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_encoder_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .cls(cls), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .busy(busy), .done(done), .err(err)
    );

    // Write monitor: every completed write must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) done_seen++;
            if (imem_we === 1'b1 && imem_ready === 1'b1) begin
                writes_seen++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
                end else begin
                    mon_e = q.pop_front();
                    if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
                        errors++;
                        $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                                 imem_addr, imem_wdata, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ref_enc(input logic [2:0] c, input logic [4:0] d, s1, s2,
                                            input logic [2:0] f3, input logic b5, input logic [12:0] im);
        logic [31:0] w;
        w = '0;
        w[14:12] = f3;
        w[19:15] = s1;
        case (c)
            3'd0: begin w[6:0] = 7'h33; w[11:7] = d; w[24:20] = s2; w[30] = b5; end
            3'd1: begin
                w[6:0] = 7'h13; w[11:7] = d; w[31:20] = im[11:0];
                if (f3 == 3'd5) begin w[31:25] = 7'd0; w[30] = b5; w[24:20] = im[4:0]; end
            end
            3'd2: begin w[6:0] = 7'h03; w[11:7] = d; w[31:20] = im[11:0]; end
            3'd3: begin w[6:0] = 7'h23; w[11:7] = im[4:0]; w[24:20] = s2; w[31:25] = im[11:5]; end
            3'd4: begin
                w[6:0] = 7'h63; w[7] = im[11]; w[11:8] = im[4:1];
                w[24:20] = s2; w[30:25] = im[10:5]; w[31] = im[12];
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = 32'h0;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                        input logic b5, input logic [12:0] im, input logic [31:0] exp_data);
        bit got = 0;
        cls = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = b5; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                if (c <= 3'd4) begin
                    q.push_back(wr_t'({exp_addr, exp_data}));
                    exp_addr += 32'd4;
                end
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_accept: cls=%0d not accepted, required accept within 20 cycles", c);
        end
    endtask

    task automatic end_session(input logic [15:0] exp_count);
        int d0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL done_pulse: got %0d pulse cycles, required 1", done_seen - d0);
        end
        checks++;
        if (count !== exp_count) begin
            errors++;
            $display("FAIL session_count: got %0d, required %0d", count, exp_count);
        end
        checks++;
        if (busy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL session_idle: busy=%b pending=%0d, required busy=0 pending=0", busy, q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; finish = 0; in_valid = 0; cls = 0; rd = 0; rs1 = 0; rs2 = 0;
        funct3 = 0; funct7b5 = 0; imm = 0; imem_ready = 1'b0;
        step(); step();
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: we=%b addr=%h data=%h, required 0/0/0", imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if (count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: count=%0d busy=%b done=%b err=%b in_ready=%b, required all 0",
                     count, busy, done, err, in_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b, required 0/0", in_ready, busy);
        end
    endtask

    task automatic test_rtype();
        int c0;
        do_start();
        imem_ready = 1'b1;
        c0 = cyc;
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 32'h002081B3);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0, 32'h402081B3);
        checks++;
        if (cyc - c0 != 2) begin
            errors++;
            $display("FAIL back_to_back: got %0d cycles for 2 accepts, required 2", cyc - c0);
        end
        end_session(16'd2);
    endtask

    task automatic test_mem();
        do_start();
        send(3'd2, 5'd5, 5'd1, 5'd0, 3'd2, 1'b0, 13'd8, 32'h0080A283);
        send(3'd3, 5'd0, 5'd1, 5'd5, 3'd2, 1'b0, 13'd12, 32'h0050A623);
        end_session(16'd2);
    endtask

    task automatic test_branch_shift();
        do_start();
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 32'hFE208CE3);
        send(3'd1, 5'd4, 5'd1, 5'd0, 3'd5, 1'b1, 13'd3, 32'h4030D213);
        end_session(16'd2);
    endtask

    task automatic test_backpressure();
        int w0;
        do_start();
        imem_ready = 1'b0;
        send(3'd1, 5'd7, 5'd2, 5'd0, 3'd0, 1'b0, 13'h1FFF, 32'hFFF10393);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_wdata !== 32'hFFF10393 || imem_addr !== 32'h0 ||
                in_ready !== 1'b0 || count !== 16'd0) begin
                errors++;
                $display("FAIL backpressure_hold: we=%b data=%h addr=%h in_ready=%b count=%0d, required 1/fff10393/0/0/0",
                         imem_we, imem_wdata, imem_addr, in_ready, count);
            end
            step();
        end
        w0 = writes_seen;
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (writes_seen - w0 != 1 || count !== 16'd1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL backpressure_release: writes=%0d count=%0d addr=%h, required 1/1/4",
                     writes_seen - w0, count, imem_addr);
        end
        end_session(16'd1);
    endtask

    task automatic test_illegal_full();
        int w0;
        bit saw_ready;
        do_start();
        imem_ready = 1'b1;
        w0 = writes_seen;
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0, 32'h0);
        step(); step();
        checks++;
        if (err !== 1'b1 || writes_seen != w0 || count !== 16'd0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL illegal_cls: err=%b writes=%0d count=%0d addr=%h, required 1/0/0/0",
                     err, writes_seen - w0, count, imem_addr);
        end
        send(3'd0, 5'd9, 5'd10, 5'd11, 3'd7, 1'b0, 13'd0, ref_enc(3'd0, 5'd9, 5'd10, 5'd11, 3'd7, 1'b0, 13'd0));
        send(3'd3, 5'd0, 5'd12, 5'd13, 3'd1, 1'b0, 13'h0FFF, ref_enc(3'd3, 5'd0, 5'd12, 5'd13, 3'd1, 1'b0, 13'h0FFF));
        cls = 3'd1; in_valid = 1'b1;
        saw_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) saw_ready = 1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (saw_ready || count !== 16'd2) begin
            errors++;
            $display("FAIL full_stall: in_ready_seen=%b count=%0d, required 0/2", saw_ready, count);
        end
        end_session(16'd2);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || count !== 16'd0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL start_clears: err=%b count=%0d addr=%h, required 0/0/0", err, count, imem_addr);
        end
        end_session(16'd0);
    endtask

    task automatic test_async_reset();
        int d0, w0;
        do_start();
        imem_ready = 1'b0;
        send(3'd2, 5'd6, 5'd3, 5'd0, 3'd2, 1'b0, 13'd16, ref_enc(3'd2, 5'd6, 5'd3, 5'd0, 3'd2, 1'b0, 13'd16));
        d0 = done_seen;
        w0 = writes_seen;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: we=%b busy=%b in_ready=%b addr=%h, required 0/0/0/0",
                     imem_we, busy, in_ready, imem_addr);
        end
        q.delete();
        #3;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (done_seen != d0 || writes_seen != w0 || count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%0d writes=%0d count=%0d busy=%b, required 0/0/0/0",
                     done_seen - d0, writes_seen - w0, count, busy);
        end
    endtask

    task automatic test_random_mix();
        logic [2:0]  c, f3;
        logic [4:0]  d, s1, s2;
        logic        b5;
        logic [12:0] im;
        imem_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            do_start();
            for (int k = 0; k < 2; k++) begin
                c = 3'($urandom_range(0, 4)); f3 = 3'($urandom); b5 = 1'($urandom);
                d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); im = 13'($urandom);
                send(c, d, s1, s2, f3, b5, im, ref_enc(c, d, s1, s2, f3, b5, im));
            end
            end_session(16'd2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch_shift();
        test_backpressure();
        test_illegal_full();
        test_async_reset();
        test_random_mix();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
